hazard_fw_unit: RTL and testbench

HAZARD_FW_UNIT -- requirements
Module: hazard_fw_unit

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_long_sb.sv | 81 ++++++++
 rtl/hazard_fw_unit.sv | 92 +++++++++
 tb/tb_hazard_fw_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding unit: operand-mux selects and long-op FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_LONG  = 2'b11;

  typedef enum logic [1:0] {
    LONG_IDLE = 2'd0,
    LONG_BUSY = 2'd1,
    LONG_DONE = 2'd2
  } long_state_t;

endpackage

// File: rtl/hazard_long_sb.sv
// Long-op scoreboard: tracks one in-flight multi-cycle op and strobes its writeback.
// Built only when HAZARD_LONG_OP_EN is defined; otherwise all outputs are tied low.
module hazard_long_sb
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LONG_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic [REG_AW-1:0] issue_rd,
  output logic              busy,
  output logic              done,
  output logic [REG_AW-1:0] wb_rd
);

`ifdef HAZARD_LONG_OP_EN
  // Issue cycle plus LONG_LAT-1 busy cycles, the last of which sees the counter at zero.
  localparam logic [3:0] CNT_LOAD = 4'(LONG_LAT - 2);

  long_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_q, rd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LONG_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    case (state_q)
      LONG_IDLE: begin
        if (issue) begin
          state_d = LONG_BUSY;
          cnt_d   = CNT_LOAD;
          rd_d    = issue_rd;
        end
      end
      LONG_BUSY: begin
        if (cnt_q == '0) state_d = LONG_DONE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      LONG_DONE: begin
        if (issue) begin
          state_d = LONG_BUSY;
          cnt_d   = CNT_LOAD;
          rd_d    = issue_rd;
        end else begin
          state_d = LONG_IDLE;
        end
      end
      default: state_d = LONG_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == LONG_BUSY);
    done = (state_q == LONG_DONE);
  end

  assign wb_rd = rd_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{clk, rst_n, issue, issue_rd};
  assign busy  = 1'b0;
  assign done  = 1'b0;
  assign wb_rd = '0;
`endif

endmodule

// File: rtl/hazard_fw_unit.sv
// Pipeline hazard unit: operand forwarding selects, load-use/long-op stalls and stall counter.
// Long-op support (select 11, long stalls) is compiled in with HAZARD_LONG_OP_EN.
module hazard_fw_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LONG_LAT = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC*REG_AW-1:0] if_id_src_i,
  input  logic                      if_id_long_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_ex_src_i,
  input  logic [REG_AW-1:0]         id_ex_rd_i,
  input  logic                      id_ex_memread_i,
  input  logic                      id_ex_long_i,
  input  logic                      ex_mem_regwrite_i,
  input  logic                      mem_wb_regwrite_i,
  input  logic [REG_AW-1:0]         ex_mem_rd_i,
  input  logic [REG_AW-1:0]         mem_wb_rd_i,
  output logic [2*NUM_SRC-1:0]      fwd_sel_o,
  output logic                      stall_o,
  output logic                      bubble_o,
  output logic                      long_busy_o,
  output logic                      long_wb_o,
  output logic [REG_AW-1:0]         long_wb_rd_o,
  output logic [15:0]               stall_cnt_o
);

  logic              long_busy;
  logic              long_done;
  logic [REG_AW-1:0] long_rd;
  logic              stall;

  // x0 is hardwired zero, so it never creates a dependency.
  function automatic logic reg_hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  hazard_long_sb #(
    .REG_AW  (REG_AW),
    .LONG_LAT(LONG_LAT)
  ) u_long_sb (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .issue   (id_ex_long_i),
    .issue_rd(id_ex_rd_i),
    .busy    (long_busy),
    .done    (long_done),
    .wb_rd   (long_rd)
  );

  // Youngest producer wins: EX/MEM, then the long-op result, then MEM/WB.
  always_comb begin
    fwd_sel_o = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (ex_mem_regwrite_i && reg_hit(id_ex_src_i[k*REG_AW +: REG_AW], ex_mem_rd_i))
        fwd_sel_o[2*k +: 2] = FWD_EXMEM;
      else if (long_done && reg_hit(id_ex_src_i[k*REG_AW +: REG_AW], long_rd))
        fwd_sel_o[2*k +: 2] = FWD_LONG;
      else if (mem_wb_regwrite_i && reg_hit(id_ex_src_i[k*REG_AW +: REG_AW], mem_wb_rd_i))
        fwd_sel_o[2*k +: 2] = FWD_MEMWB;
      else
        fwd_sel_o[2*k +: 2] = FWD_REG;
    end
  end

  always_comb begin
    stall = if_id_long_i && long_busy;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_ex_memread_i && reg_hit(if_id_src_i[k*REG_AW +: REG_AW], id_ex_rd_i))
        stall = 1'b1;
      if (long_busy && reg_hit(if_id_src_i[k*REG_AW +: REG_AW], long_rd))
        stall = 1'b1;
    end
  end

  assign stall_o      = stall;
  assign bubble_o     = stall;
  assign long_busy_o  = long_busy | long_done;
  assign long_wb_o    = long_done;
  assign long_wb_rd_o = long_rd;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      stall_cnt_o <= '0;
    else if (stall && (stall_cnt_o != 16'hFFFF))
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end

endmodule

// File: tb/tb_hazard_fw_unit.sv
// Self-checking bench for hazard_fw_unit: cycle-numbered reference model plus directed literal checks.
// Long-op expectations follow HAZARD_LONG_OP_EN the same way the design does.
module tb_hazard_fw_unit;

  localparam int AW  = 5;
  localparam int NS  = 2;
  localparam int LAT = 4;
`ifdef HAZARD_LONG_OP_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NS*AW-1:0]  if_src = '0;
  logic              if_long = 1'b0;
  logic [NS*AW-1:0]  ex_src = '0;
  logic [AW-1:0]     ex_rd = '0;
  logic              ex_memread = 1'b0;
  logic              ex_long = 1'b0;
  logic              em_wr = 1'b0;
  logic              mw_wr = 1'b0;
  logic [AW-1:0]     em_rd = '0;
  logic [AW-1:0]     mw_rd = '0;
  logic [2*NS-1:0]   fwd_sel;
  logic              stall;
  logic              bubble;
  logic              long_busy;
  logic              long_wb;
  logic [AW-1:0]     long_wb_rd;
  logic [15:0]       stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_fw_unit #(.REG_AW(AW), .NUM_SRC(NS), .LONG_LAT(LAT)) dut (
    .clk_i            (clk),
    .rst_i            (rst_n),
    .if_id_src_i      (if_src),
    .if_id_long_i     (if_long),
    .id_ex_src_i      (ex_src),
    .id_ex_rd_i       (ex_rd),
    .id_ex_memread_i  (ex_memread),
    .id_ex_long_i     (ex_long),
    .ex_mem_regwrite_i(em_wr),
    .mem_wb_regwrite_i(mw_wr),
    .ex_mem_rd_i      (em_rd),
    .mem_wb_rd_i      (mw_rd),
    .fwd_sel_o        (fwd_sel),
    .stall_o          (stall),
    .bubble_o         (bubble),
    .long_busy_o      (long_busy),
    .long_wb_o        (long_wb),
    .long_wb_rd_o     (long_wb_rd),
    .stall_cnt_o      (stall_cnt)
  );

  // Reference model: an accepted long op issued in cycle c writes back in cycle c+LAT.
  int            cyc = 0;
  bit            pend = 1'b0;
  int            due = 0;
  logic [AW-1:0] lrd = '0;
  int            scount = 0;

  function automatic logic hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic logic [AW-1:0] srcOf(input logic [NS*AW-1:0] v, input int k);
    return v[k*AW +: AW];
  endfunction

  function automatic logic mBusy();
    return LONG_EN && rst_n && pend && (cyc < due);
  endfunction

  function automatic logic mDone();
    return LONG_EN && rst_n && pend && (cyc == due);
  endfunction

  function automatic logic mStall();
    logic s;
    s = if_long && mBusy();
    for (int k = 0; k < NS; k++) begin
      if (ex_memread && hit(srcOf(if_src, k), ex_rd)) s = 1'b1;
      if (mBusy() && hit(srcOf(if_src, k), lrd)) s = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [2*NS-1:0] mFwd();
    logic [2*NS-1:0] r;
    logic [AW-1:0]   s;
    r = '0;
    for (int k = 0; k < NS; k++) begin
      s = srcOf(ex_src, k);
      if (em_wr && hit(s, em_rd))      r[2*k +: 2] = 2'b10;
      else if (mDone() && hit(s, lrd)) r[2*k +: 2] = 2'b11;
      else if (mw_wr && hit(s, mw_rd)) r[2*k +: 2] = 2'b01;
      else                             r[2*k +: 2] = 2'b00;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    logic st;
    if (!rst_n) begin
      pend   = 1'b0;
      lrd    = '0;
      scount = 0;
    end else begin
      st = mStall();
      if (st && scount < 65535) scount++;
      if (LONG_EN && ex_long && (!pend || cyc >= due)) begin
        pend = 1'b1;
        due  = cyc + LAT;
        lrd  = ex_rd;
      end else if (pend && cyc >= due) begin
        pend = 1'b0;
      end
    end
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("fwd_sel", 32'(fwd_sel), 32'(mFwd()));
    checkOutput("stall", 32'(stall), 32'(mStall()));
    checkOutput("bubble", 32'(bubble), 32'(mStall()));
    checkOutput("long_busy", 32'(long_busy), 32'(mBusy() | mDone()));
    checkOutput("long_wb", 32'(long_wb), 32'(mDone()));
    checkOutput("long_wb_rd", 32'(long_wb_rd), rst_n ? 32'(lrd) : 32'd0);
    checkOutput("stall_cnt", 32'(stall_cnt), rst_n ? 32'(scount) : 32'd0);
  end

  task automatic applyStimulus(input logic [NS*AW-1:0] ifs, input logic ifl, input logic [NS*AW-1:0] exs,
                               input logic [AW-1:0] exr, input logic mr, input logic exl,
                               input logic ew, input logic [AW-1:0] er, input logic mw, input logic [AW-1:0] mwr);
    @(posedge clk);
    #1;
    if_src = ifs; if_long = ifl; ex_src = exs; ex_rd = exr; ex_memread = mr; ex_long = exl;
    em_wr = ew; em_rd = er; mw_wr = mw; mw_rd = mwr;
  endtask

  task automatic idleCycle();
    applyStimulus('0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic doReset();
    idleCycle();
    rst_n = 1'b0;
    idleCycle();
    rst_n = 1'b1;
  endtask

  function automatic logic [NS*AW-1:0] randSrcs();
    logic [NS*AW-1:0] v;
    for (int k = 0; k < NS; k++) v[k*AW +: AW] = AW'($urandom_range(0, 7));
    return v;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("reset_long_busy", 32'(long_busy), 32'd0);
    checkOutput("reset_long_wb", 32'(long_wb), 32'd0);
    checkOutput("reset_long_wb_rd", 32'(long_wb_rd), 32'd0);

    // Load-use on r5 for a single cycle.
    applyStimulus({5'd0, 5'd5}, 1'b0, '0, 5'd5, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("loaduse_stall", 32'(stall), 32'd1);
    checkOutput("loaduse_bubble", 32'(bubble), 32'd1);
    idleCycle();
    @(negedge clk);
    checkOutput("loaduse_cnt", 32'(stall_cnt), 32'd1);
    checkOutput("loaduse_released", 32'(stall), 32'd0);

    applyStimulus('0, 1'b0, {5'd0, 5'd3}, '0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 5'd3);
    @(negedge clk);
    checkOutput("newest_wins_src0", 32'(fwd_sel[1:0]), 32'h2);
    applyStimulus('0, 1'b0, {5'd0, 5'd6}, '0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd6);
    @(negedge clk);
    checkOutput("rd0_src1", 32'(fwd_sel[3:2]), 32'h0);
    checkOutput("memwb_src0", 32'(fwd_sel[1:0]), 32'h1);

    // Long op rd=7, back-to-back rd=9 issued in the DONE cycle.
    applyStimulus('0, 1'b0, '0, 5'd7, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("long_c0_busy", 32'(long_busy), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      applyStimulus({5'd0, 5'd7}, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      checkOutput("long_raw_stall", 32'(stall), 32'(LONG_EN));
      checkOutput("long_busy_mid", 32'(long_busy), 32'(LONG_EN));
      checkOutput("long_wb_early", 32'(long_wb), 32'd0);
    end
    applyStimulus({5'd0, 5'd7}, 1'b0, {5'd0, 5'd7}, 5'd9, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("long_wb_c4", 32'(long_wb), 32'(LONG_EN));
    checkOutput("long_wb_rd_c4", 32'(long_wb_rd), LONG_EN ? 32'd7 : 32'd0);
    checkOutput("long_fwd_c4", 32'(fwd_sel[1:0]), LONG_EN ? 32'h3 : 32'h0);
    checkOutput("long_done_nostall", 32'(stall), 32'd0);
    for (int c = 5; c <= 7; c++) begin
      idleCycle();
      @(negedge clk);
      checkOutput("b2b_wb_early", 32'(long_wb), 32'd0);
    end
    idleCycle();
    @(negedge clk);
    checkOutput("b2b_wb_c8", 32'(long_wb), 32'(LONG_EN));
    checkOutput("b2b_wb_rd_c8", 32'(long_wb_rd), LONG_EN ? 32'd9 : 32'd0);

    // Long op rd=11 abandoned by a reset two cycles after issue.
    applyStimulus('0, 1'b0, '0, 5'd11, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    idleCycle();
    idleCycle();
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(long_busy), 32'd0);
    checkOutput("abort_wb_rd", 32'(long_wb_rd), 32'd0);
    idleCycle();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("abort_no_wb", 32'(long_wb), 32'd0);
      idleCycle();
    end

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(randSrcs(), ($urandom_range(0, 3) == 0), randSrcs(), AW'($urandom_range(0, 7)),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                    1'($urandom), AW'($urandom_range(0, 7)), 1'($urandom), AW'($urandom_range(0, 7)));
      rst_n = ($urandom_range(0, 199) != 0);
    end
    rst_n = 1'b1;

    // Saturate the stall counter with a held load-use hazard.
    doReset();
    applyStimulus({5'd0, 5'd5}, 1'b0, '0, 5'd5, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    checkOutput("stall_cnt_saturated", 32'(stall_cnt), 32'h0000FFFF);
    idleCycle();
    @(negedge clk);
    checkOutput("stall_cnt_held", 32'(stall_cnt), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
